// File: rtl/pat_io_bank_if.sv
// Register read/write port between the PAT core and the I/O bank.
// The master issues strobes; the slave returns registered read data.
interface pat_io_bank_if #(
   parameter int D_WIDTH = 8,
   parameter int ADR_W   = 4
);
   logic [ADR_W-1:0]   adr;
   logic               wr_en;
   logic [D_WIDTH-1:0] wr_data;
   logic               rd_en;
   logic [D_WIDTH-1:0] rd_data;
   logic               rd_valid;

   modport master (
      output adr, wr_en, wr_data, rd_en,
      input  rd_data, rd_valid
   );

   modport slave (
      input  adr, wr_en, wr_data, rd_en,
      output rd_data, rd_valid
   );
endinterface

// File: rtl/pat_io_bank.sv
// N-port bidirectional byte I/O bank: synchronised inputs with sticky change flags,
// latched outputs with per-port PWM gating, and a combined interrupt line.
module pat_io_bank #(
   parameter int D_WIDTH   = 8,
   parameter int N_PORTS   = 4,
   parameter int PWM_WIDTH = 8,
   parameter int ADR_W     = $clog2(N_PORTS) + 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N_PORTS*D_WIDTH-1:0] pads_in,
   output logic [N_PORTS*D_WIDTH-1:0] pads_out,
   pat_io_bank_if.slave               bus,
   output logic                       irq,
   output logic                       pwm_wrap
);
   localparam int IDX_W = ADR_W - 2;
   localparam int MIN_W = (D_WIDTH < PWM_WIDTH) ? D_WIDTH : PWM_WIDTH;

   logic [D_WIDTH-1:0]   s1_r    [N_PORTS];
   logic [D_WIDTH-1:0]   s2_r    [N_PORTS];
   logic [D_WIDTH-1:0]   s3_r    [N_PORTS];
   logic [D_WIDTH-1:0]   latch_r [N_PORTS];
   logic [D_WIDTH-1:0]   flags_r [N_PORTS];
   logic [PWM_WIDTH-1:0] duty_r  [N_PORTS];
   logic [N_PORTS-1:0]   pwm_en_r;
   logic [N_PORTS-1:0]   irq_en_r;
   logic [1:0]           primed_r;
   logic [PWM_WIDTH-1:0] pwm_cnt_r;
   logic [D_WIDTH-1:0]   rd_data_r;
   logic                 rd_valid_r;

   logic [IDX_W-1:0]     idx_s;
   logic [1:0]           sel_s;
   logic [N_PORTS-1:0]   hit_s;
   logic [D_WIDTH-1:0]   flags_nxt_s [N_PORTS];
   logic [D_WIDTH-1:0]   view_s;
   logic [D_WIDTH-1:0]   clr_s;
   logic [D_WIDTH-1:0]   set_s;
   logic [D_WIDTH-1:0]   rd_mux_s;
   logic                 irq_nxt_s;

   // Only the low MIN_W duty bits are reachable through the data bus.
   function automatic logic [D_WIDTH-1:0] duty_to_bus(input logic [PWM_WIDTH-1:0] duty);
      logic [D_WIDTH-1:0] v;
      v = '0;
      v[MIN_W-1:0] = duty[MIN_W-1:0];
      return v;
   endfunction

   function automatic logic [PWM_WIDTH-1:0] duty_from_bus(input logic [PWM_WIDTH-1:0] old,
                                                          input logic [D_WIDTH-1:0]   data);
      logic [PWM_WIDTH-1:0] v;
      v = old;
      v[MIN_W-1:0] = data[MIN_W-1:0];
      return v;
   endfunction

   assign bus.rd_data  = rd_data_r;
   assign bus.rd_valid = rd_valid_r;

   // Address decode, read mux, flag next-state and interrupt combine
   always_comb begin
      idx_s     = bus.adr[ADR_W-1:2];
      sel_s     = bus.adr[1:0];
      hit_s     = '0;
      rd_mux_s  = '0;
      irq_nxt_s = 1'b0;
      view_s    = '0;
      clr_s     = '0;
      set_s     = '0;
      for (int p = 0; p < N_PORTS; p++) begin
         hit_s[p] = (idx_s == IDX_W'(p));
         case (sel_s)
            2'd0:    view_s = s2_r[p];
            2'd1:    view_s = flags_r[p];
            2'd2:    view_s = D_WIDTH'({irq_en_r[p], pwm_en_r[p]});
            2'd3:    view_s = duty_to_bus(duty_r[p]);
            default: view_s = '0;
         endcase
         rd_mux_s = rd_mux_s | (hit_s[p] ? view_s : '0);
         // Set is OR-ed in after the clear so a same-cycle set wins.
         clr_s = (bus.wr_en && hit_s[p] && (sel_s == 2'd1)) ? bus.wr_data : '0;
         set_s = (primed_r == 2'd3) ? (s2_r[p] ^ s3_r[p]) : '0;
         flags_nxt_s[p] = (flags_r[p] & ~clr_s) | set_s;
         irq_nxt_s = irq_nxt_s | (irq_en_r[p] & (|flags_r[p]));
      end
   end

   // Register file, synchronisers, PWM counter and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         primed_r   <= 2'd0;
         pwm_cnt_r  <= '0;
         pwm_wrap   <= 1'b0;
         irq        <= 1'b0;
         rd_data_r  <= '0;
         rd_valid_r <= 1'b0;
         pads_out   <= '0;
         pwm_en_r   <= '0;
         irq_en_r   <= '0;
         for (int p = 0; p < N_PORTS; p++) begin
            s1_r[p]    <= '0;
            s2_r[p]    <= '0;
            s3_r[p]    <= '0;
            latch_r[p] <= '0;
            flags_r[p] <= '0;
            duty_r[p]  <= '0;
         end
      end else begin
         primed_r   <= (primed_r == 2'd3) ? primed_r : primed_r + 2'd1;
         pwm_cnt_r  <= pwm_cnt_r + PWM_WIDTH'(1);
         pwm_wrap   <= &pwm_cnt_r;
         irq        <= irq_nxt_s;
         rd_valid_r <= bus.rd_en;
         if (bus.rd_en) begin
            rd_data_r <= rd_mux_s;
         end else begin
            rd_data_r <= rd_data_r;
         end
         for (int p = 0; p < N_PORTS; p++) begin
            s1_r[p]    <= pads_in[p*D_WIDTH +: D_WIDTH];
            s2_r[p]    <= s1_r[p];
            s3_r[p]    <= s2_r[p];
            flags_r[p] <= flags_nxt_s[p];
            pads_out[p*D_WIDTH +: D_WIDTH] <= pwm_en_r[p]
               ? (latch_r[p] & {D_WIDTH{pwm_cnt_r < duty_r[p]}})
               : latch_r[p];
            if (bus.wr_en && hit_s[p]) begin
               case (sel_s)
                  2'd0: latch_r[p] <= bus.wr_data;
                  2'd1: begin end
                  2'd2: begin
                     pwm_en_r[p] <= bus.wr_data[0];
                     irq_en_r[p] <= bus.wr_data[1];
                  end
                  2'd3:    duty_r[p] <= duty_from_bus(duty_r[p], bus.wr_data);
                  default: begin end
               endcase
            end else begin
               latch_r[p] <= latch_r[p];
            end
         end
      end
   end
endmodule

// File: tb/tb_pat_io_bank.sv
// Scoreboard bench for pat_io_bank: a pad-history reference model predicts every
// output; reads are queued at issue and popped by a negedge monitor.
module tb_pat_io_bank;
   localparam int NP = 3;
   localparam int DW = 8;
   localparam int PW = 8;
   localparam int AW = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic [NP*DW-1:0] pads;
   logic [NP*DW-1:0] pads_out;
   logic             irq;
   logic             pwm_wrap;

   pat_io_bank_if #(.D_WIDTH(DW), .ADR_W(AW)) io_bus ();

   pat_io_bank #(.D_WIDTH(DW), .N_PORTS(NP), .PWM_WIDTH(PW), .ADR_W(AW)) dut (
      .clk(clk), .reset(reset), .pads_in(pads), .pads_out(pads_out),
      .bus(io_bus), .irq(irq), .pwm_wrap(pwm_wrap)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit checking = 1'b0;
   int const_exp = -1;

   logic [7:0]       rd_q [$];
   logic [7:0]       m_latch [NP];
   logic [7:0]       m_flags [NP];
   logic [7:0]       m_duty  [NP];
   logic             m_pwm_en[NP];
   logic             m_irq_en[NP];
   logic [NP*DW-1:0] m_hist  [3];   // pad samples from the last three edges, newest first
   int               m_n;           // non-reset edges since reset
   logic [NP*DW-1:0] exp_pads;
   logic             exp_irq;
   logic             exp_wrap;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void model_edge();
      int port;
      logic [7:0] v;
      logic [7:0] set;
      logic [7:0] clr;
      if (reset) begin
         for (int p = 0; p < NP; p++) begin
            m_latch[p] = 8'h00; m_flags[p] = 8'h00; m_duty[p] = 8'h00;
            m_pwm_en[p] = 1'b0; m_irq_en[p] = 1'b0;
         end
         for (int i = 0; i < 3; i++) m_hist[i] = '0;
         m_n = 0; exp_pads = '0; exp_irq = 1'b0; exp_wrap = 1'b0;
         return;
      end
      exp_irq = 1'b0;
      for (int p = 0; p < NP; p++) begin
         exp_irq = exp_irq | (m_irq_en[p] && (m_flags[p] != 8'h00));
         if (!m_pwm_en[p]) exp_pads[p*8 +: 8] = m_latch[p];
         else exp_pads[p*8 +: 8] = ((m_n % 256) < int'(m_duty[p])) ? m_latch[p] : 8'h00;
      end
      exp_wrap = (((m_n + 1) % 256) == 0);
      port = int'(io_bus.adr[3:2]);
      if (io_bus.rd_en) begin
         v = 8'h00;
         if (port < NP) begin
            case (io_bus.adr[1:0])
               2'd0: v = m_hist[1][port*8 +: 8];
               2'd1: v = m_flags[port];
               2'd2: v = {6'b0, m_irq_en[port], m_pwm_en[port]};
               default: v = m_duty[port];
            endcase
         end
         rd_q.push_back((const_exp >= 0) ? 8'(const_exp) : v);
      end
      for (int p = 0; p < NP; p++) begin
         set = (m_n >= 3) ? (m_hist[1][p*8 +: 8] ^ m_hist[2][p*8 +: 8]) : 8'h00;
         clr = (io_bus.wr_en && port == p && io_bus.adr[1:0] == 2'd1) ? io_bus.wr_data : 8'h00;
         m_flags[p] = (m_flags[p] & ~clr) | set;
      end
      if (io_bus.wr_en && port < NP) begin
         case (io_bus.adr[1:0])
            2'd0: m_latch[port] = io_bus.wr_data;
            2'd2: begin m_pwm_en[port] = io_bus.wr_data[0]; m_irq_en[port] = io_bus.wr_data[1]; end
            2'd3: m_duty[port] = io_bus.wr_data;
            default: ;
         endcase
      end
      m_hist[2] = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = pads;
      m_n++;
   endfunction

   task automatic step(input logic rst, input logic we, input logic re,
                       input logic [AW-1:0] a, input logic [DW-1:0] d, input int cexp);
      reset = rst; io_bus.wr_en = we; io_bus.rd_en = re;
      io_bus.adr = a; io_bus.wr_data = d; const_exp = cexp;
      @(posedge clk);
      model_edge();
      #1;
      reset = 1'b0; io_bus.wr_en = 1'b0; io_bus.rd_en = 1'b0; const_exp = -1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, -1);
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      step(1'b0, 1'b1, 1'b0, a, d, -1);
   endtask

   task automatic rdc(input logic [AW-1:0] a, input int exp);
      step(1'b0, 1'b0, 1'b1, a, 8'h00, exp);
   endtask

   // Monitor: every read retires exactly one cycle after issue; other outputs track the model.
   always @(negedge clk) begin
      logic [7:0] e;
      if (checking) begin
         chk("rd_valid", {31'b0, io_bus.rd_valid}, {31'b0, rd_q.size() != 0});
         if (rd_q.size() != 0) begin
            e = rd_q.pop_front();
            if (io_bus.rd_valid) chk("rd_data", {24'b0, io_bus.rd_data}, {24'b0, e});
         end
         chk("pads_out", {8'b0, pads_out}, {8'b0, exp_pads});
         chk("irq", {31'b0, irq}, {31'b0, exp_irq});
         chk("pwm_wrap", {31'b0, pwm_wrap}, {31'b0, exp_wrap});
      end
   end

   initial begin
      int hi;
      int lo;
      pads = '1;
      io_bus.adr = '0; io_bus.wr_en = 1'b0; io_bus.rd_en = 1'b0; io_bus.wr_data = '0;
      reset = 1'b1;
      step(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, -1);
      checking = 1'b1;
      step(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, -1);

      // Pads held high through reset: the filling synchroniser must not raise flags.
      idle(10);
      rdc(4'h0, 8'hFF);
      rdc(4'h1, 8'h00);
      chk("reset_irq", {31'b0, irq}, 32'd0);
      chk("reset_pads_out", {8'b0, pads_out}, 32'd0);

      pads = '0;
      idle(4);
      for (int p = 0; p < NP; p++) wr(4'(p*4 + 1), 8'hFF);
      wr(4'h6, 8'h02);
      idle(2);
      pads = 24'h000800;
      idle(3);
      rdc(4'h5, 8'h08);
      chk("irq_on_flag", {31'b0, irq}, 32'd1);
      wr(4'h5, 8'h08);
      idle(1);
      chk("irq_after_w1c", {31'b0, irq}, 32'd0);
      rdc(4'h5, 8'h00);

      // W1C lands on the same edge the flag is set.
      pads = 24'h200800;
      idle(2);
      wr(4'h9, 8'h20);
      rdc(4'h9, 8'h20);

      wr(4'h0, 8'hA5); wr(4'h3, 8'd64); wr(4'h2, 8'h01);
      idle(1);
      hi = 0; lo = 0;
      for (int i = 0; i < 256; i++) begin
         idle(1);
         if (pads_out[7:0] == 8'hA5) hi++;
         if (pads_out[7:0] == 8'h00) lo++;
      end
      chk("pwm64_high", hi, 64);
      chk("pwm64_low", lo, 192);
      wr(4'h3, 8'd0);
      idle(1);
      lo = 0;
      for (int i = 0; i < 256; i++) begin
         idle(1);
         if (pads_out[7:0] == 8'h00) lo++;
      end
      chk("pwm0_low", lo, 256);
      wr(4'h2, 8'h00);
      idle(1);
      hi = 0;
      for (int i = 0; i < 256; i++) begin
         idle(1);
         if (pads_out[7:0] == 8'hA5) hi++;
      end
      chk("pwm_off_const", hi, 256);

      wr(4'hC, 8'h5A); wr(4'hE, 8'h03); wr(4'hF, 8'h10);
      rdc(4'hC, 8'h00);
      rdc(4'hE, 8'h00);
      rdc(4'h2, 8'h00);

      wr(4'h3, 8'h40);
      step(1'b0, 1'b1, 1'b1, 4'h3, 8'h33, 8'h40);
      rdc(4'h3, 8'h33);
      step(1'b0, 1'b1, 1'b1, 4'h0, 8'h77, -1);

      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 7) == 0) pads[$urandom_range(0, NP*DW-1)] ^= 1'b1;
         step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 2) == 0), 4'($urandom), 8'($urandom), -1);
      end

      // Reset overrides a same-cycle read and clears every register.
      pads = '0;
      step(1'b1, 1'b1, 1'b1, 4'h0, 8'hFF, -1);
      for (int a = 0; a < 16; a++) rdc(4'(a), 8'h00);
      idle(2);
      chk("rd_queue_drained", rd_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/pat_io_bank.md
# pat_io_bank

Parametrised PAT I/O subsystem replacing the fixed three-port input/output wiring around the PAT core. It provides N_PORTS bidirectional byte ports, each with:
- a two-flop input synchroniser and sticky per-bit change flags;
- an output latch with optional PWM gating from a shared free-running counter.

The PAT reaches the block through a small registered read/write port. A combined interrupt-style `irq` line lets firmware poll one bit instead of every port.

## Interface

Parameters:
- D_WIDTH, 8, port width in bits
- N_PORTS, 4, number of ports; legal range 2..16
- PWM_WIDTH, 8, PWM counter and duty width
- ADR_W, $clog2(N_PORTS)+2, register address width (derived)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all state
- pads_in  in  N_PORTS*D_WIDTH  asynchronous pad inputs; port p occupies bits [p*D_WIDTH +: D_WIDTH]
- pads_out  out  N_PORTS*D_WIDTH  registered pad outputs, same packing as `pads_in`
- adr  in  ADR_W  register address; `adr[ADR_W-1:2]` = port index, `adr[1:0]` = register
- wr_en  in  1  write strobe
- wr_data  in  D_WIDTH  write data
- rd_en  in  1  read strobe
- rd_data  out  D_WIDTH  registered read data
- rd_valid  out  1  high the cycle after an accepted `rd_en`
- irq  out  1  registered OR of enabled port change flags
- pwm_wrap  out  1  one-cycle pulse when the PWM counter wraps to 0

## Operation

Per-port registers (`adr[1:0]`):
- 0 DATA: read returns the synchronised input value (sync stage 2); write loads the output latch.
- 1 FLAGS: read returns the sticky change flags. Writing 1 clears that bit (W1C); writing 0 has no effect.
- 2 MODE: bit0 `pwm_en`, bit1 `irq_en`; remaining bits read 0, writes ignored.
- 3 DUTY: low PWM_WIDTH bits are the duty value. Bits above PWM_WIDTH read 0. If PWM_WIDTH > D_WIDTH, only the low D_WIDTH bits are accessible.

Address decode:
- A port index >= N_PORTS is out of range: writes are ignored and reads return 0 with `rd_valid` still asserted.

Input path:
- Chain per bit: s1 <= pad, s2 <= s1, s3 <= s2.
- Change condition: s2 != s3 sets the flag bit.
- Flag setting is suppressed until a 2-bit `primed` counter reaches 3, i.e. for the first 3 cycles after reset deasserts. This masks the artificial edges produced while the synchroniser fills.
- Set and W1C clear on the same bit in the same cycle: set wins.

Output path:
- `pwm_cnt` increments every cycle and wraps from 2^PWM_WIDTH-1 to 0.
- `level` = (`pwm_cnt` < duty), unsigned compare. Duty 0 gives level always 0; duty 2^PWM_WIDTH-1 gives level 0 for one count per period.
- Next `pads_out` for port p = `pwm_en` ? (latch & {D_WIDTH{level}}) : latch.
- All ports share one `pwm_cnt`; each port has its own duty.

Interrupt:
- Next `irq` = OR over p of (`irq_en`[p] & |flags[p]).

Reads and writes:
- `wr_en` and `rd_en` may both be asserted in the same cycle. The read returns the pre-write value.
- For FLAGS, "pre-write" means before both set and clear in that cycle.

Reset (sync, high) clears:
- latches, flags, MODE, DUTY, s1/s2/s3, `primed`, `pwm_cnt`;
- outputs: `pads_out` = 0, `rd_data` = 0, `rd_valid` = 0, `irq` = 0, `pwm_wrap` = 0.

Reset asserted mid-operation:
- Overrides any same-cycle write or read.
- The read is dropped: no `rd_valid` follows.

## Timing

- Pad edge sampled at edge k: s2 updates at k+1; visible via DATA read issued at k+2. The flag sets at edge k+2 (s2 != s3), provided `primed`.
- `irq` rises one edge after the flag sets.
- DATA/MODE/DUTY write at edge n: register updates at n; `pads_out` reflects it at n+1.
- FLAGS W1C at edge n: flag clears at n; `irq` drops at n+1 if no other enabled flag is set.
- `rd_en` at edge n: `rd_data`/`rd_valid` valid after edge n, i.e. during cycle n+1. Back-to-back reads are allowed; `rd_data` holds its last value when `rd_valid` = 0.
- `pwm_wrap` is high during the cycle in which `pwm_cnt` = 0. The first pulse occurs 2^PWM_WIDTH cycles after reset release.

## Test plan

- Reset: drive `pads_in` all-ones through reset and 10 cycles after -> flags stay 0, `irq` 0, `pads_out` 0, DATA read of port 0 = 0xFF.
- Change flag: port 1 bit 3 toggles 0->1 -> FLAGS(1) = 0x08; with `irq_en` = 1, `irq` = 1 one cycle later. Write 0x08 to FLAGS(1) -> flag and `irq` clear.
- Set/clear collision: toggle a pad bit timed so its flag sets in the same cycle as a W1C of that bit -> flag remains 1.
- PWM, PWM_WIDTH = 8: latch 0xA5, `pwm_en` = 1, duty 64 -> `pads_out` = 0xA5 for 64 of every 256 cycles, 0x00 otherwise. Duty 0 -> always 0x00. `pwm_en` = 0 -> constant 0xA5.
- Address range, N_PORTS = 3: write to port index 3 -> no state change; read -> 0 with `rd_valid`. Simultaneous read and write of DATA -> old value returned.
- Mid-operation reset: assert reset together with `rd_en` -> no `rd_valid`; all registers read 0 afterwards.
